// File: rtl/assoc_buf_pkg.sv
// Shared definitions for the associative buffer family.
// Contents:
//   CTRL_W                   width of the ctrl opcode bus
//   CTRL_NONE .. CTRL_LOOKUP opcode values; code 7 is reserved and treated as NONE
// The older CLR/LOAD/INCR buffer and the benches use the same constants.
package assoc_buf_pkg;

   localparam int CTRL_W = 3;

   localparam logic [CTRL_W-1:0] CTRL_NONE   = 3'd0;
   localparam logic [CTRL_W-1:0] CTRL_CLR    = 3'd1;
   localparam logic [CTRL_W-1:0] CTRL_LOAD   = 3'd2;
   localparam logic [CTRL_W-1:0] CTRL_INCR   = 3'd3;
   localparam logic [CTRL_W-1:0] CTRL_DECR   = 3'd4;
   localparam logic [CTRL_W-1:0] CTRL_DEL    = 3'd5;
   localparam logic [CTRL_W-1:0] CTRL_LOOKUP = 3'd6;

endpackage

// File: rtl/assoc_lru_entry.sv
// One entry of assoc_lru_buffer.
// Holds the valid, key, data and LRU age registers and compares the stored key
// against the broadcast op key. Age updates follow the broadcast events:
//   ins   : the selected entry takes age 0; every other valid entry ages by one
//   touch : the selected entry takes age 0; valid entries younger than
//           bcast_age (the touched entry's old age) age by one
//   del   : the selected entry is invalidated; valid entries older than
//           bcast_age (the deleted entry's age) become one younger
// The top asserts at most one of ins/touch/del per cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               invalidate the entry (CLR op)
//   cmp_key / match   op key and the hit flag for it
//   sel               this entry is the target of the current op
//   ins, touch, del   broadcast age events, bcast_age their reference age
//   data_we           write new_data into the selected entry
//   new_key, new_data key/data written on insert or update
//   entry_*           stored state, read by the top for muxing
module assoc_lru_entry
   import assoc_buf_pkg::*;
#(
   parameter int KEY_WIDTH  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int AGE_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [KEY_WIDTH-1:0]  cmp_key,
   output logic                  match,
   input  logic                  sel,
   input  logic                  ins,
   input  logic                  touch,
   input  logic                  del,
   input  logic [AGE_WIDTH-1:0]  bcast_age,
   input  logic                  data_we,
   input  logic [KEY_WIDTH-1:0]  new_key,
   input  logic [DATA_WIDTH-1:0] new_data,
   output logic                  entry_valid,
   output logic [KEY_WIDTH-1:0]  entry_key,
   output logic [DATA_WIDTH-1:0] entry_data,
   output logic [AGE_WIDTH-1:0]  entry_age
);

   assign match = entry_valid && (entry_key == cmp_key);

   always_ff @(posedge clk) begin
      if (rst) begin
         entry_valid <= 1'b0;
         entry_key   <= '0;
         entry_data  <= '0;
         entry_age   <= '0;
      end else if (clr) begin
         entry_valid <= 1'b0;
         entry_age   <= '0;
      end else begin
         if (sel && data_we) begin
            entry_data <= new_data;
         end
         if (ins) begin
            if (sel) begin
               entry_valid <= 1'b1;
               entry_key   <= new_key;
               entry_age   <= '0;
            end else if (entry_valid) begin
               entry_age <= entry_age + 1'b1;
            end
         end
         if (touch) begin
            if (sel) begin
               entry_age <= '0;
            end else if (entry_valid && (entry_age < bcast_age)) begin
               entry_age <= entry_age + 1'b1;
            end
         end
         if (del) begin
            if (sel) begin
               entry_valid <= 1'b0;
               entry_age   <= '0;
            end else if (entry_valid && (entry_age > bcast_age)) begin
               entry_age <= entry_age - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/assoc_lru_buffer.sv
// Associative key->data store with LRU replacement and in-place INCR/DECR.
// One op per clock, results registered (latency 1).
// Build option: define ASSOC_LRU_BUF_SAT_EN to make INCR/DECR saturate at the
// data range limits; without it they wrap.
// Ports:
//   clk, rst      clock, synchronous active-high reset (overrides ctrl)
//   ctrl          opcode (see assoc_buf_pkg), key/data_input its operands
//   data_output   result data of the last op
//   valid         last op hit or wrote an entry
//   evict         one-cycle pulse when a LOAD replaced the LRU entry
//   evict_key     key of the replaced entry, meaningful while evict is high
//   full, count   occupancy after the last op
module assoc_lru_buffer
   import assoc_buf_pkg::*;
#(
   parameter int KEY_WIDTH   = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int BUFFER_SIZE = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CTRL_W-1:0]                ctrl,
   input  logic [KEY_WIDTH-1:0]             key,
   input  logic [DATA_WIDTH-1:0]            data_input,
   output logic [DATA_WIDTH-1:0]            data_output,
   output logic                             valid,
   output logic                             evict,
   output logic [KEY_WIDTH-1:0]             evict_key,
   output logic                             full,
   output logic [$clog2(BUFFER_SIZE+1)-1:0] count
);

   localparam int AGE_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = $clog2(BUFFER_SIZE+1);

   logic [BUFFER_SIZE-1:0] match_vec;
   logic [BUFFER_SIZE-1:0] valid_vec;
   logic [KEY_WIDTH-1:0]   key_arr  [BUFFER_SIZE];
   logic [DATA_WIDTH-1:0]  data_arr [BUFFER_SIZE];
   logic [AGE_W-1:0]       age_arr  [BUFFER_SIZE];

   logic [BUFFER_SIZE-1:0] sel;
   logic                   ins, touch, del, data_we, clr_op;
   logic [AGE_W-1:0]       bcast_age;
   logic [DATA_WIDTH-1:0]  new_data;

   logic                   hit;
   logic [AGE_W-1:0]       hit_idx, free_idx, victim_idx;
   logic [DATA_WIDTH-1:0]  hit_data, arith_data;
   logic [AGE_W-1:0]       hit_age;

   logic [DATA_WIDTH-1:0]  dout_nxt;
   logic                   valid_nxt, evict_nxt;
   logic [KEY_WIDTH-1:0]   ekey_nxt;
   logic [CNT_W-1:0]       count_nxt;

   for (genvar g = 0; g < BUFFER_SIZE; g++) begin : g_entry
      assoc_lru_entry #(
         .KEY_WIDTH (KEY_WIDTH),
         .DATA_WIDTH(DATA_WIDTH),
         .AGE_WIDTH (AGE_W)
      ) u_entry (
         .clk        (clk),
         .rst        (rst),
         .clr        (clr_op),
         .cmp_key    (key),
         .match      (match_vec[g]),
         .sel        (sel[g]),
         .ins        (ins),
         .touch      (touch),
         .del        (del),
         .bcast_age  (bcast_age),
         .data_we    (data_we),
         .new_key    (key),
         .new_data   (new_data),
         .entry_valid(valid_vec[g]),
         .entry_key  (key_arr[g]),
         .entry_data (data_arr[g]),
         .entry_age  (age_arr[g])
      );
   end

   // Keys are unique, so at most one match bit is set. The free-slot scan runs
   // downward so the lowest free index wins. When full, exactly one valid entry
   // carries the oldest age and becomes the victim.
   always_comb begin
      hit        = |match_vec;
      hit_idx    = '0;
      free_idx   = '0;
      victim_idx = '0;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
         if (match_vec[i]) hit_idx = AGE_W'(i);
         if (valid_vec[i] && (age_arr[i] == AGE_W'(BUFFER_SIZE-1))) victim_idx = AGE_W'(i);
      end
      for (int i = BUFFER_SIZE-1; i >= 0; i--) begin
         if (!valid_vec[i]) free_idx = AGE_W'(i);
      end
      hit_data = data_arr[hit_idx];
      hit_age  = age_arr[hit_idx];
   end

   always_comb begin
      arith_data = hit_data;
`ifdef ASSOC_LRU_BUF_SAT_EN
      if (ctrl == CTRL_INCR) begin
         arith_data = (hit_data == '1) ? hit_data : hit_data + 1'b1;
      end else begin
         arith_data = (hit_data == '0) ? hit_data : hit_data - 1'b1;
      end
`else
      if (ctrl == CTRL_INCR) begin
         arith_data = hit_data + 1'b1;
      end else begin
         arith_data = hit_data - 1'b1;
      end
`endif
   end

   always_comb begin
      sel       = '0;
      ins       = 1'b0;
      touch     = 1'b0;
      del       = 1'b0;
      data_we   = 1'b0;
      clr_op    = 1'b0;
      bcast_age = '0;
      new_data  = '0;
      dout_nxt  = data_output;
      valid_nxt = valid;
      evict_nxt = 1'b0;
      ekey_nxt  = evict_key;
      count_nxt = count;
      case (ctrl)
         CTRL_CLR: begin
            clr_op    = 1'b1;
            dout_nxt  = '0;
            valid_nxt = 1'b0;
            count_nxt = '0;
         end
         CTRL_LOAD: begin
            data_we   = 1'b1;
            new_data  = data_input;
            dout_nxt  = data_input;
            valid_nxt = 1'b1;
            if (hit) begin
               sel[hit_idx] = 1'b1;
               touch        = 1'b1;
               bcast_age    = hit_age;
            end else if (full) begin
               sel[victim_idx] = 1'b1;
               ins             = 1'b1;
               evict_nxt       = 1'b1;
               ekey_nxt        = key_arr[victim_idx];
            end else begin
               sel[free_idx] = 1'b1;
               ins           = 1'b1;
               count_nxt     = count + 1'b1;
            end
         end
         CTRL_INCR, CTRL_DECR: begin
            dout_nxt  = '0;
            valid_nxt = 1'b0;
            if (hit) begin
               sel[hit_idx] = 1'b1;
               touch        = 1'b1;
               bcast_age    = hit_age;
               data_we      = 1'b1;
               new_data     = arith_data;
               dout_nxt     = arith_data;
               valid_nxt    = 1'b1;
            end
         end
         CTRL_DEL: begin
            dout_nxt  = '0;
            valid_nxt = 1'b0;
            if (hit) begin
               sel[hit_idx] = 1'b1;
               del          = 1'b1;
               bcast_age    = hit_age;
               dout_nxt     = hit_data;
               valid_nxt    = 1'b1;
               count_nxt    = count - 1'b1;
            end
         end
         CTRL_LOOKUP: begin
            dout_nxt  = '0;
            valid_nxt = 1'b0;
            if (hit) begin
               sel[hit_idx] = 1'b1;
               touch        = 1'b1;
               bcast_age    = hit_age;
               dout_nxt     = hit_data;
               valid_nxt    = 1'b1;
            end
         end
         default: begin
            // NONE and the reserved code hold everything except the evict pulse.
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_output <= '0;
         valid       <= 1'b0;
         evict       <= 1'b0;
         evict_key   <= '0;
         count       <= '0;
         full        <= 1'b0;
      end else begin
         data_output <= dout_nxt;
         valid       <= valid_nxt;
         evict       <= evict_nxt;
         evict_key   <= ekey_nxt;
         count       <= count_nxt;
         full        <= (count_nxt == CNT_W'(BUFFER_SIZE));
      end
   end

endmodule

// File: tb/tb_assoc_lru_buffer.sv
// Bench for assoc_lru_buffer (KEY_WIDTH=4, DATA_WIDTH=4, BUFFER_SIZE=4).
// The reference model keeps the entries as a queue ordered most- to
// least-recently used; the LRU victim is simply the tail of the queue.
module tb_assoc_lru_buffer;
   import assoc_buf_pkg::*;

`ifdef ASSOC_LRU_BUF_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int NENT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CTRL_W-1:0] ctrl = CTRL_NONE;
   logic [3:0]        key = '0;
   logic [3:0]        data_input = '0;
   logic [3:0]        data_output;
   logic              valid;
   logic              evict;
   logic [3:0]        evict_key;
   logic              full;
   logic [2:0]        count;

   assoc_lru_buffer #(
      .KEY_WIDTH  (4),
      .DATA_WIDTH (4),
      .BUFFER_SIZE(NENT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ctrl       (ctrl),
      .key        (key),
      .data_input (data_input),
      .data_output(data_output),
      .valid      (valid),
      .evict      (evict),
      .evict_key  (evict_key),
      .full       (full),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] k;
      logic [3:0] d;
   } ent_t;

   ent_t       mq[$];
   logic [3:0] e_dout;
   logic       e_valid;
   logic       e_evict;
   logic [3:0] e_ekey;
   bit         ekey_chk;

   int compared   = 0;
   int mismatched = 0;

   function automatic int find_key(logic [3:0] k);
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].k == k) return i;
      end
      return -1;
   endfunction

   task automatic model_step(logic r, logic [2:0] op, logic [3:0] k, logic [3:0] d);
      int   f;
      ent_t e;
      e_evict  = 1'b0;
      ekey_chk = 1'b0;
      if (r) begin
         mq.delete();
         e_dout   = '0;
         e_valid  = 1'b0;
         e_ekey   = '0;
         ekey_chk = 1'b1;
         return;
      end
      f = find_key(k);
      case (op)
         CTRL_CLR: begin
            mq.delete();
            e_dout  = '0;
            e_valid = 1'b0;
         end
         CTRL_LOAD: begin
            if (f >= 0) begin
               mq.delete(f);
            end else if (mq.size() == NENT) begin
               e_ekey   = mq[mq.size()-1].k;
               e_evict  = 1'b1;
               ekey_chk = 1'b1;
               void'(mq.pop_back());
            end
            e.k = k;
            e.d = d;
            mq.push_front(e);
            e_dout  = d;
            e_valid = 1'b1;
         end
         CTRL_INCR, CTRL_DECR: begin
            if (f >= 0) begin
               e = mq[f];
               mq.delete(f);
               if (op == CTRL_INCR) begin
                  if (!(SAT && e.d == 4'hF)) e.d = e.d + 4'd1;
               end else begin
                  if (!(SAT && e.d == 4'h0)) e.d = e.d - 4'd1;
               end
               mq.push_front(e);
               e_dout  = e.d;
               e_valid = 1'b1;
            end else begin
               e_dout  = '0;
               e_valid = 1'b0;
            end
         end
         CTRL_DEL: begin
            if (f >= 0) begin
               e_dout  = mq[f].d;
               e_valid = 1'b1;
               mq.delete(f);
            end else begin
               e_dout  = '0;
               e_valid = 1'b0;
            end
         end
         CTRL_LOOKUP: begin
            if (f >= 0) begin
               e = mq[f];
               mq.delete(f);
               mq.push_front(e);
               e_dout  = e.d;
               e_valid = 1'b1;
            end else begin
               e_dout  = '0;
               e_valid = 1'b0;
            end
         end
         default: begin
         end
      endcase
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(logic r, logic [2:0] op, logic [3:0] k, logic [3:0] d);
      rst        = r;
      ctrl       = op;
      key        = k;
      data_input = d;
      @(posedge clk);
      #1;
      model_step(r, op, k, d);
      check("data_output", 32'(data_output), 32'(e_dout));
      check("valid",       32'(valid),       32'(e_valid));
      check("evict",       32'(evict),       32'(e_evict));
      if (ekey_chk) check("evict_key", 32'(evict_key), 32'(e_ekey));
      check("count",       32'(count),       32'(mq.size()));
      check("full",        32'(full),        32'(mq.size() == NENT));
      rst  = 1'b0;
      ctrl = CTRL_NONE;
   endtask

   initial begin
      logic [2:0] op;
      // 1: reset, single LOAD, NONE holds
      step(1'b1, CTRL_NONE, 4'd0, 4'd0);
      step(1'b0, CTRL_LOAD, 4'd1, 4'hE);
      step(1'b0, CTRL_NONE, 4'd0, 4'd0);
      step(1'b0, 3'd7,      4'd0, 4'd0);
      // 2: INCR across the top of the range, DECR across zero
      step(1'b0, CTRL_INCR, 4'd1, 4'd0);
      step(1'b0, CTRL_INCR, 4'd1, 4'd0);
      step(1'b0, CTRL_LOAD, 4'd1, 4'h0);
      step(1'b0, CTRL_DECR, 4'd1, 4'd0);
      // 3: fill, touch key 1, LOAD a fifth key to evict the LRU
      for (int i = 1; i <= 4; i++) step(1'b0, CTRL_LOAD, 4'(i), 4'(i + 8));
      step(1'b0, CTRL_LOOKUP, 4'd1, 4'd0);
      step(1'b0, CTRL_LOAD,   4'd5, 4'h5);
      step(1'b0, CTRL_LOOKUP, 4'd2, 4'd0);
      // 4: delete, refill the freed slot, arithmetic on an absent key
      step(1'b0, CTRL_DEL,    4'd3, 4'd0);
      step(1'b0, CTRL_LOAD,   4'd6, 4'h6);
      step(1'b0, CTRL_INCR,   4'd9, 4'd0);
      step(1'b0, CTRL_DECR,   4'd9, 4'd0);
      step(1'b0, CTRL_DEL,    4'd9, 4'd0);
      step(1'b0, CTRL_LOOKUP, 4'd6, 4'd0);
      // 5: CLR while full, then reset colliding with a LOAD
      step(1'b0, CTRL_CLR,    4'd0, 4'd0);
      step(1'b0, CTRL_LOOKUP, 4'd5, 4'd0);
      step(1'b0, CTRL_LOAD,   4'd7, 4'h7);
      step(1'b1, CTRL_LOAD,   4'd8, 4'h8);
      step(1'b0, CTRL_LOOKUP, 4'd8, 4'd0);
      // randomized ops over a small key space so hits and evictions are common
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: op = CTRL_LOAD;
            3:       op = CTRL_INCR;
            4:       op = CTRL_DECR;
            5:       op = CTRL_DEL;
            6, 7:    op = CTRL_LOOKUP;
            8:       op = ($urandom_range(0, 3) == 0) ? CTRL_CLR : CTRL_NONE;
            default: op = 3'd7;
         endcase
         step(($urandom_range(0, 79) == 0), op, 4'($urandom_range(1, 6)),
              4'($urandom_range(0, 15)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
